// File: rtl/awp_pkg.sv
// Shared types and constants for the AWP loop sequencer.
// State encodings, op codes and FIC geometry.
package awp_pkg;

    localparam int FIC_W = 6;
    localparam logic [FIC_W-1:0] FIC_MAX = 6'd63;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_NORM = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LWAIT = 3'd2,
        S_CLR   = 3'd3,
        S_CWAIT = 3'd4,
        S_STEP  = 3'd5,
        S_SWAIT = 3'd6,
        S_DONE  = 3'd7
    } state_t;

endpackage

// File: rtl/awp_loop_seq.sv
// Iteration sequencer driving the FIC loop counter.
// Every output is a flop fed from the next-state decode.
module awp_loop_seq
    import awp_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst_,
    input  logic             start,
    input  logic [0:1]       op,
    input  logic [0:FIC_W-1] count_in,
    input  logic [0:FIC_W-1] fic,
    input  logic             norm_done,
    input  logic             abort,
    output logic             fic_rab_,
    output logic             fic_load_,
    output logic             fic_cda,
    output logic             fic_cua_,
    output logic [0:FIC_W-1] fic_in,
    output logic             step,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q;
    state_t           state_n;
    logic [1:0]       op_q;
    logic [1:0]       op_n;
    logic [0:FIC_W-1] cnt_n;
    logic             abt_q;
    logic             abt_n;
    logic             errf_q;
    logic             errf_n;

    logic             is_norm;
    logic             rab_d;
    logic             load_d;
    logic             cda_d;
    logic             cua_d;
    logic             step_d;
    logic             busy_d;
    logic             done_d;
    logic             err_d;

    // Next-state decode; abort overrides every busy state but DONE.
    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        cnt_n   = fic_in;
        abt_n   = abt_q;
        errf_n  = errf_q;
        unique case (state_q)
            S_IDLE: begin
                abt_n  = 1'b0;
                errf_n = 1'b0;
                if (start && !abort) begin
                    op_n  = op;
                    cnt_n = count_in;
                    unique case (op)
                        OP_MUL,
                        OP_DIV:  state_n = S_LOAD;
                        OP_NORM: state_n = S_CLR;
                        OP_RSVD: begin
                            state_n = S_DONE;
                            errf_n  = 1'b1;
                        end
                    endcase
                end
            end
            S_LOAD:  state_n = S_LWAIT;
            S_LWAIT: state_n = (fic == '0) ? S_DONE : S_STEP;
            S_CLR:   state_n = abt_q ? S_DONE : S_CWAIT;
            S_CWAIT: state_n = norm_done ? S_DONE : S_STEP;
            S_STEP:  state_n = S_SWAIT;
            S_SWAIT: begin
                if (op_q == OP_NORM) begin
                    if (norm_done) begin
                        state_n = S_DONE;
                    end else if (fic == FIC_MAX) begin
                        state_n = S_DONE;
                        errf_n  = 1'b1;
                    end else begin
                        state_n = S_STEP;
                    end
                end else begin
                    state_n = (fic == '0) ? S_DONE : S_STEP;
                end
            end
            S_DONE:  state_n = S_IDLE;
        endcase
        // A clear already in flight serves the abort; skip a second pulse.
        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            abt_n   = 1'b1;
            errf_n  = 1'b1;
            state_n = (state_q == S_CLR) ? S_DONE : S_CLR;
        end
    end

    // Strobe decode from the state being entered.
    always_comb begin
        is_norm = (op_n == OP_NORM);
        rab_d   = (state_n == S_CLR);
        load_d  = (state_n != S_LOAD);
        cda_d   = (state_n == S_STEP) && !is_norm;
        cua_d   = !((state_n == S_STEP) && is_norm);
        step_d  = (state_n == S_STEP);
        busy_d  = (state_n != S_IDLE);
        done_d  = (state_n == S_DONE);
        err_d   = done_d && errf_n;
    end

    // State and registered outputs; reset holds FIC cleared.
    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            state_q   <= S_IDLE;
            op_q      <= OP_MUL;
            abt_q     <= 1'b0;
            errf_q    <= 1'b0;
            fic_in    <= '0;
            fic_rab_  <= 1'b1;
            fic_load_ <= 1'b1;
            fic_cda   <= 1'b0;
            fic_cua_  <= 1'b1;
            step      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_n;
            op_q      <= op_n;
            abt_q     <= abt_n;
            errf_q    <= errf_n;
            fic_in    <= cnt_n;
            fic_rab_  <= rab_d;
            fic_load_ <= load_d;
            fic_cda   <= cda_d;
            fic_cua_  <= cua_d;
            step      <= step_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_awp_loop_seq.sv
// Directed bench for awp_loop_seq.
// A behavioural FIC counter is the load on the sequencer.
module tb_awp_loop_seq;

    logic       clk_sys;
    logic       rst_;
    logic       start;
    logic [0:1] op;
    logic [0:5] count_in;
    logic [0:5] fic;
    logic       norm_done;
    logic       abort;
    logic       fic_rab_;
    logic       fic_load_;
    logic       fic_cda;
    logic       fic_cua_;
    logic [0:5] fic_in;
    logic       step;
    logic       busy;
    logic       done;
    logic       err;

    int checks;
    int failures;

    awp_loop_seq dut (
        .clk_sys   (clk_sys),
        .rst_      (rst_),
        .start     (start),
        .op        (op),
        .count_in  (count_in),
        .fic       (fic),
        .norm_done (norm_done),
        .abort     (abort),
        .fic_rab_  (fic_rab_),
        .fic_load_ (fic_load_),
        .fic_cda   (fic_cda),
        .fic_cua_  (fic_cua_),
        .fic_in    (fic_in),
        .step      (step),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // FIC counter: async clear, sync load / count, modulo 64.
    always @(posedge clk_sys or posedge fic_rab_) begin
        if (fic_rab_)
            fic <= '0;
        else if (!fic_load_)
            fic <= fic_in;
        else if (fic_cda)
            fic <= fic - 6'd1;
        else if (!fic_cua_)
            fic <= fic + 6'd1;
    end

    int         r_done;
    bit         r_err;
    int         r_steps;
    int         r_loads;
    int         r_clears;
    logic [5:0] r_fic;
    int         r_viol;

    task automatic run_op(
        input logic [1:0] o,
        input logic [5:0] n,
        input int         norm_at,
        input int         abort_at,
        input bit         hold,
        input int         limit
    );
        bit p_rab, p_load, p_cda, p_cua;
        p_rab = 0; p_load = 0; p_cda = 0; p_cua = 0;
        r_done = -1; r_err = 0; r_steps = 0; r_loads = 0;
        r_clears = 0; r_fic = '0; r_viol = 0;
        @(negedge clk_sys);
        start = 1'b1;
        op = o;
        count_in = n;
        @(posedge clk_sys);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk_sys);
            if (!hold) start = 1'b0;
            abort = 1'b0;
            if (fic_rab_ && p_rab) r_viol++;
            if (!fic_load_ && p_load) r_viol++;
            if (fic_cda && p_cda) r_viol++;
            if (!fic_cua_ && p_cua) r_viol++;
            p_rab = fic_rab_;
            p_load = !fic_load_;
            p_cda = fic_cda;
            p_cua = !fic_cua_;
            if (fic_rab_) r_clears++;
            if (!fic_load_) r_loads++;
            if (step) begin
                r_steps++;
                if (norm_at > 0 && r_steps == norm_at) norm_done = 1'b1;
                if (abort_at > 0 && r_steps == abort_at) abort = 1'b1;
            end
            if (done) begin
                r_done = c;
                r_err = err;
                r_fic = fic;
                start = 1'b0;
                break;
            end
        end
        norm_done = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        #1 rst_ = 1'b0;
        #12;
        checks++;
        if ({fic_rab_, fic_load_, fic_cda, fic_cua_, step, busy, done, err}
            !== 8'b1101_0000 || fic_in !== 6'd0) begin
            failures++;
            $display("FAIL reset_outs got=%b fic_in=%0d want=11010000 0",
                {fic_rab_, fic_load_, fic_cda, fic_cua_, step, busy, done, err},
                fic_in);
        end
        checks++;
        if (fic !== 6'd0) begin
            failures++;
            $display("FAIL reset_fic got=%0d want=0", fic);
        end
        @(negedge clk_sys);
        rst_ = 1'b1;
        @(negedge clk_sys);
        checks++;
        if (fic_rab_ !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_rab got=%b want=0", fic_rab_);
        end
    endtask

    task automatic test_mul5();
        run_op(2'b00, 6'd5, 0, 0, 0, 40);
        checks++;
        if (r_done !== 13 || r_err !== 1'b0) begin
            failures++;
            $display("FAIL mul5_done got=c%0d err=%b want=c13 err=0", r_done, r_err);
        end
        checks++;
        if (r_steps !== 5 || r_loads !== 1 || r_fic !== 6'd0) begin
            failures++;
            $display("FAIL mul5_counts got steps=%0d loads=%0d fic=%0d want 5 1 0",
                r_steps, r_loads, r_fic);
        end
        checks++;
        if (r_viol !== 0 || fic_in !== 6'd5) begin
            failures++;
            $display("FAIL mul5_strobes got viol=%0d fic_in=%0d want 0 5", r_viol, fic_in);
        end
    endtask

    task automatic test_div0();
        run_op(2'b01, 6'd0, 0, 0, 0, 20);
        checks++;
        if (r_done !== 3 || r_err !== 1'b0 || r_steps !== 0 || r_loads !== 1) begin
            failures++;
            $display("FAIL div0 got c%0d err=%b steps=%0d loads=%0d want c3 0 0 1",
                r_done, r_err, r_steps, r_loads);
        end
    endtask

    task automatic test_norm3();
        run_op(2'b10, 6'd0, 3, 0, 0, 40);
        checks++;
        if (r_done !== 9 || r_err !== 1'b0) begin
            failures++;
            $display("FAIL norm3_done got=c%0d err=%b want=c9 err=0", r_done, r_err);
        end
        checks++;
        if (r_fic !== 6'd3 || r_steps !== 3 || r_clears !== 1 || r_viol !== 0) begin
            failures++;
            $display("FAIL norm3_counts got fic=%0d steps=%0d clr=%0d viol=%0d want 3 3 1 0",
                r_fic, r_steps, r_clears, r_viol);
        end
    endtask

    task automatic test_norm_overflow();
        run_op(2'b10, 6'd0, 0, 0, 0, 200);
        checks++;
        if (r_done !== 129 || r_err !== 1'b1) begin
            failures++;
            $display("FAIL normov_done got=c%0d err=%b want=c129 err=1", r_done, r_err);
        end
        checks++;
        if (r_fic !== 6'd63 || r_steps !== 63 || r_viol !== 0) begin
            failures++;
            $display("FAIL normov_counts got fic=%0d steps=%0d viol=%0d want 63 63 0",
                r_fic, r_steps, r_viol);
        end
    endtask

    task automatic test_abort();
        run_op(2'b00, 6'd40, 0, 10, 0, 200);
        checks++;
        if (r_done !== 23 || r_err !== 1'b1) begin
            failures++;
            $display("FAIL abort_done got=c%0d err=%b want=c23 err=1", r_done, r_err);
        end
        checks++;
        if (r_steps !== 10 || r_clears !== 1 || r_fic !== 6'd0) begin
            failures++;
            $display("FAIL abort_counts got steps=%0d clr=%0d fic=%0d want 10 1 0",
                r_steps, r_clears, r_fic);
        end
    endtask

    task automatic test_back_to_back();
        int extra;
        extra = 0;
        run_op(2'b00, 6'd2, 0, 0, 1, 40);
        checks++;
        if (r_done !== 7 || r_loads !== 1 || r_steps !== 2) begin
            failures++;
            $display("FAIL held_start got c%0d loads=%0d steps=%0d want c7 1 2",
                r_done, r_loads, r_steps);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_sys);
            if (busy || !fic_load_) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL held_start_idle got busy_cycles=%0d want=0", extra);
        end
    endtask

    task automatic test_rsvd();
        run_op(2'b11, 6'd9, 0, 0, 0, 10);
        checks++;
        if (r_done !== 1 || r_err !== 1'b1 || r_loads !== 0) begin
            failures++;
            $display("FAIL rsvd got c%0d err=%b loads=%0d want c1 1 0",
                r_done, r_err, r_loads);
        end
    endtask

    task automatic test_abort_idle();
        @(negedge clk_sys);
        start = 1'b1;
        abort = 1'b1;
        op = 2'b00;
        count_in = 6'd4;
        @(negedge clk_sys);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || fic_load_ !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle got busy=%b load_=%b want 0 1", busy, fic_load_);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        int dones;
        guard = 0;
        dones = 0;
        @(negedge clk_sys);
        start = 1'b1;
        op = 2'b00;
        count_in = 6'd5;
        @(negedge clk_sys);
        start = 1'b0;
        while (!step && guard < 10) begin
            @(negedge clk_sys);
            guard++;
        end
        rst_ = 1'b0;
        #1;
        checks++;
        if ({fic_rab_, fic_load_, fic_cda, fic_cua_, step, busy, done, err}
            !== 8'b1101_0000 || fic !== 6'd0 || guard >= 10) begin
            failures++;
            $display("FAIL reset_mid got=%b fic=%0d guard=%0d want=11010000 0",
                {fic_rab_, fic_load_, fic_cda, fic_cua_, step, busy, done, err},
                fic, guard);
        end
        @(negedge clk_sys);
        rst_ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet got active=%0d want=0", dones);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        start = 1'b0;
        op = 2'b00;
        count_in = '0;
        norm_done = 1'b0;
        abort = 1'b0;
        rst_ = 1'b1;
        test_reset();
        test_mul5();
        test_div0();
        test_norm3();
        test_norm_overflow();
        test_abort();
        test_back_to_back();
        test_rsvd();
        test_abort_idle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/awp_loop_seq.md
# awp_loop_seq

Iteration sequencer for the AWP loop counter (FIC). Accepts a multiply, divide or normalize request and issues glitch-free, registered, one-cycle control strobes to FIC: clear, parallel load, count-down and count-up. Watches the 6-bit FIC value and the datapath normalize flag, emits one datapath step strobe per iteration, and ends with a one-cycle done/err pulse. Sits directly upstream of FIC and drives all four of its control inputs.

## Interface
- No parameters. FIC width is fixed at 6 bits; bit 0 is the MSB.
- clk_sys  in  1  system clock; all state changes on the rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  [0:1]  00 MUL, 01 DIV, 10 NORM, 11 reserved.
- count_in  in  [0:5]  iteration count for MUL and DIV; latched when start is accepted.
- fic  in  [0:5]  FIC output value.
- norm_done  in  1  datapath reports the mantissa is normalized.
- abort  in  1  synchronous cancel.
- fic_rab_  out  1  FIC clear, active high.
- fic_load_  out  1  FIC parallel load, active low.
- fic_cda  out  1  FIC count down, active high.
- fic_cua_  out  1  FIC count up, active low.
- fic_in  out  [0:5]  FIC load value (latched count_in).
- step  out  1  datapath iteration strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only while done is high.

## Operation
- States: IDLE, LOAD, LWAIT, CLR, CWAIT, STEP, SWAIT, DONE.
- Every strobe is asserted for exactly one cycle and followed by at least one cycle inactive. This guarantees a clean rising edge on the FIC composite clock.
- Inactive strobe levels: fic_rab_=0, fic_load_=1, fic_cda=0, fic_cua_=1.
- IDLE + start:
  - op 00 or 01 goes to LOAD.
  - op 10 goes to CLR.
  - op 11 goes to DONE with err=1.
  - op and count_in are latched on acceptance.
- LOAD: fic_load_=0. Next state LWAIT.
- LWAIT: if fic==0, go to DONE. Otherwise go to STEP.
- CLR: fic_rab_=1. Next state CWAIT.
- CWAIT: if norm_done, go to DONE. Otherwise go to STEP.
- STEP: step=1.
  - MUL/DIV also assert fic_cda=1.
  - NORM also asserts fic_cua_=0.
  - Next state SWAIT.
- SWAIT for MUL/DIV: if fic==0, go to DONE. Otherwise go to STEP.
- SWAIT for NORM:
  - norm_done goes to DONE with err=0.
  - Otherwise fic==63 goes to DONE with err=1 (shift overflow).
  - Otherwise go to STEP.
  - norm_done has priority over fic==63.
- DONE: done=1 and err as determined. Next state IDLE.
- abort in any state except IDLE and DONE: go to CLR_ABORT, which is the CLR state with a flag set. It pulses fic_rab_=1, then goes to DONE with err=1. Any strobe already issued completes normally.
- abort in IDLE has priority over start: start is ignored and nothing happens.
- start while busy is ignored and not queued.
- FIC arithmetic is modulo 64. This block never counts FIC past 0 downward or past 63 upward.

## Timing
- Let c0 be the cycle in which start is sampled.
- MUL/DIV with count N: load strobe in c1; step strobes in c3, c5, …, c(2N+1); done in c(2N+3).
- MUL/DIV with N=0: done in c3 and no step.
- NORM with k steps (k ≤ 63): clear in c1, done in c(2k+3).
- Reserved op: done with err=1 in c1.
- fic is sampled one cycle after the strobe that changed it, in the LWAIT, CWAIT and SWAIT states.
- Reset values:
  - State is IDLE.
  - fic_rab_=1, so FIC is cleared asynchronously while rst_ is low.
  - fic_load_=1, fic_cda=0, fic_cua_=1, fic_in=0.
  - step=0, busy=0, done=0, err=0.
  - fic_rab_ goes to 0 in the first cycle after rst_ is released.
- Reset mid-operation: immediate return to IDLE, no done pulse, FIC cleared.

## Structure
- Shared header or package awp_pkg holds:
  - state encodings;
  - op codes OP_MUL, OP_DIV, OP_NORM, OP_RSVD;
  - FIC_W=6 and FIC_MAX=6'd63.
- Single flat module with no sub-modules. All outputs come straight from flops.
- The bench instantiates the existing FIC counter as the load on this block.

## Test plan
- MUL with count_in=5: exactly 5 step pulses; fic steps 5→0; done in c13 with err=0.
- DIV with count_in=0: no step; done in c3; fic_load_ pulses once.
- NORM with norm_done rising after the 3rd step: fic=3; done in c9 with err=0.
- NORM with norm_done held low: 63 steps; fic=63; done with err=1.
- MUL with count_in=40, abort after the 10th step: fic_rab_ pulses; fic=0; done with err=1; no further step.
- Boundary cases:
  - start held high while busy gives exactly one operation.
  - op=11 gives done/err in c1.
  - rst_ low during STEP clears all outputs and fic on the next sample.
